dm_unit: RTL

Data-memory unit downstream of the single-cycle/pipelined datapath. It consumes the datapath's memory address, store data and access controls, and returns extended load data. It is a byte-addressed, little-endian data memory with word/half/byte accesses, sign/zero extension and misalignment/range error reporting. A request/ready/done handshake lets the datapath stall on the two-cycle load path.

---
 rtl/dm_pkg.sv | 30 +++
 rtl/dm_ram.sv | 38 +++
 rtl/dm_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared encodings and the load-lane extension helper for the data-memory unit.
package dm_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_LOAD_RD = 2'b01,
    S_RESP    = 2'b10
  } state_t;

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] dm_extend(input logic [31:0] word,
                                            input logic [1:0]  sz,
                                            input logic        sx,
                                            input logic [1:0]  lane);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (sz)
      SZ_BYTE: res = sx ? {{24{sh[7]}}, sh[7:0]}   : {24'h000000, sh[7:0]};
      SZ_HALF: res = sx ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port word RAM with byte-enabled synchronous write and registered read.
module dm_ram
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-3:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Array has no reset so a unit reset never disturbs stored contents.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < 4; i++) begin
          if (i_be[i]) begin
            r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_unit.sv
// Byte-addressed little-endian data memory with request/ready/done handshake,
// sign/zero-extended loads and misalignment/range/size error reporting.
module dm_unit
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [1:0]        r_lane;
  logic [31:0]       r_rdata;
  logic              r_ready;
  logic              r_done;
  logic              r_err;

  logic              w_req_err;
  logic              w_accept;
  logic              w_ram_en;
  logic              w_ram_we;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ram_rdata;
  logic [31:0]       w_load_data;

  dm_ram #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk   (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_be    (w_be),
    .i_addr  (addr[ADDR_W-1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Next-state, request error check, byte enables and load extension.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_ram_en = 1'b0;
    w_ram_we = 1'b0;
    w_be     = 4'b0000;
    w_wdata  = wdata;

    w_req_err = (size == 2'b11)
              | ((size == SZ_WORD) && (addr[1:0] != 2'b00))
              | ((size == SZ_HALF) && addr[0])
              | (addr[31:ADDR_W] != {(32-ADDR_W){1'b0}});

    case (size)
      SZ_WORD: begin
        w_be    = 4'b1111;
        w_wdata = wdata;
      end
      SZ_HALF: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {wdata[15:0], wdata[15:0]};
      end
      SZ_BYTE: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = wdata;
      end
    endcase

    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          if (w_req_err) begin
            w_next = S_RESP;
          end else if (we) begin
            w_ram_en = 1'b1;
            w_ram_we = 1'b1;
            w_next   = S_RESP;
          end else begin
            w_ram_en = 1'b1;
            w_next   = S_LOAD_RD;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD_RD: w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase

    w_load_data = dm_extend(w_ram_rdata, r_size, r_sext, r_lane);
  end

  // State, latched request fields and registered handshake/data outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_size  <= SZ_WORD;
      r_sext  <= 1'b0;
      r_lane  <= 2'b00;
      r_rdata <= 32'h0000_0000;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      r_done  <= (w_next == S_RESP);
      r_err   <= (w_next == S_RESP) && (r_state == S_IDLE) && w_req_err;
      if (w_accept) begin
        r_size <= size;
        r_sext <= sext;
        r_lane <= addr[1:0];
      end
      if (w_accept && w_req_err) begin
        r_rdata <= 32'h0000_0000;
      end else if (r_state == S_LOAD_RD) begin
        r_rdata <= w_load_data;
      end
    end
  end

  assign ready = r_ready;
  assign done  = r_done;
  assign err   = r_err;
  assign rdata = r_rdata;

endmodule
